// File: rtl/main_mul_acc_pipe.sv
// rtl/main_mul_acc_pipe.sv - pipelined signed/unsigned multiplier with accumulate and sticky overflow
module main_mul_acc_pipe #(
    parameter int din0_WIDTH  = 170,
    parameter int din1_WIDTH  = 53,
    parameter int dout_WIDTH  = 170,
    parameter int NUM_STAGE   = 5,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_vld,
    input  logic                  in_acc,
    input  logic                  in_first,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_vld,
    output logic                  acc_ovf
);

    // Full-precision product width: each operand gains one extension bit.
    localparam int PW = din0_WIDTH + din1_WIDTH + 2;
    // Number of delay registers between the product and the final stage.
    localparam int ND = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 1;
    // Overflow is judged as signed if either operand is two's complement.
    localparam bit SIGNED_MODE = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    logic [din0_WIDTH-1:0] s1_a;
    logic [din1_WIDTH-1:0] s1_b;
    logic                  s1_vld;
    logic                  s1_acc;
    logic                  s1_first;

    // Stage 1: capture operands and control on every enabled edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_a     <= '0;
            s1_b     <= '0;
            s1_vld   <= 1'b0;
            s1_acc   <= 1'b0;
            s1_first <= 1'b0;
        end else if (ce) begin
            s1_a     <= din0;
            s1_b     <= din1;
            s1_vld   <= in_vld;
            s1_acc   <= in_acc;
            s1_first <= in_first;
        end
    end

    logic                 a_sign;
    logic                 b_sign;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod_full;
    logic [dout_WIDTH-1:0] prod_r;

    // Extend both operands to full product width so one signed multiply covers every signedness mix.
    assign a_sign    = (DIN0_SIGNED != 0) ? s1_a[din0_WIDTH-1] : 1'b0;
    assign b_sign    = (DIN1_SIGNED != 0) ? s1_b[din1_WIDTH-1] : 1'b0;
    assign a_ext     = {{(PW - din0_WIDTH){a_sign}}, s1_a};
    assign b_ext     = {{(PW - din1_WIDTH){b_sign}}, s1_b};
    assign prod_full = a_ext * b_ext;

    // Fit the product to the result width: keep low bits or sign-extend.
    generate
        if (dout_WIDTH < PW) begin : g_trunc
            logic unused_prod_hi;
            assign unused_prod_hi = ^prod_full[PW-1:dout_WIDTH];
            assign prod_r         = prod_full[dout_WIDTH-1:0];
        end else if (dout_WIDTH == PW) begin : g_same
            assign prod_r = prod_full;
        end else begin : g_sext
            assign prod_r = {{(dout_WIDTH - PW){prod_full[PW-1]}}, prod_full};
        end
    endgenerate

    logic [dout_WIDTH-1:0] fin_p;
    logic                  fin_vld;
    logic                  fin_acc;
    logic                  fin_first;

    generate
        if (NUM_STAGE > 2) begin : g_dly
            logic [dout_WIDTH-1:0] dly_p     [ND];
            logic                  dly_vld   [ND];
            logic                  dly_acc   [ND];
            logic                  dly_first [ND];

            // Delay line carrying the product with its valid and mode bits.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < ND; i++) begin
                        dly_p[i]     <= '0;
                        dly_vld[i]   <= 1'b0;
                        dly_acc[i]   <= 1'b0;
                        dly_first[i] <= 1'b0;
                    end
                end else if (ce) begin
                    dly_p[0]     <= prod_r;
                    dly_vld[0]   <= s1_vld;
                    dly_acc[0]   <= s1_acc;
                    dly_first[0] <= s1_first;
                    for (int i = 1; i < ND; i++) begin
                        dly_p[i]     <= dly_p[i-1];
                        dly_vld[i]   <= dly_vld[i-1];
                        dly_acc[i]   <= dly_acc[i-1];
                        dly_first[i] <= dly_first[i-1];
                    end
                end
            end

            assign fin_p     = dly_p[ND-1];
            assign fin_vld   = dly_vld[ND-1];
            assign fin_acc   = dly_acc[ND-1];
            assign fin_first = dly_first[ND-1];
        end else begin : g_nodly
            assign fin_p     = prod_r;
            assign fin_vld   = s1_vld;
            assign fin_acc   = s1_acc;
            assign fin_first = s1_first;
        end
    endgenerate

    logic [dout_WIDTH-1:0] acc_r;
    logic [dout_WIDTH:0]   sum_ext;
    logic [dout_WIDTH-1:0] sum;
    logic                  sum_ovf;

    // Accumulate adder and its overflow detection.
    assign sum_ext = {1'b0, acc_r} + {1'b0, fin_p};
    assign sum     = sum_ext[dout_WIDTH-1:0];
    assign sum_ovf = SIGNED_MODE
                   ? ((acc_r[dout_WIDTH-1] == fin_p[dout_WIDTH-1]) && (sum[dout_WIDTH-1] != acc_r[dout_WIDTH-1]))
                   : sum_ext[dout_WIDTH];

    // Final stage: plain result, accumulator restart, or accumulate with sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout    <= '0;
            out_vld <= 1'b0;
            acc_r   <= '0;
            acc_ovf <= 1'b0;
        end else if (ce) begin
            out_vld <= fin_vld;
            if (fin_vld) begin
                if (!fin_acc) begin
                    dout <= fin_p;
                end else if (fin_first) begin
                    acc_r   <= fin_p;
                    dout    <= fin_p;
                    acc_ovf <= 1'b0;
                end else begin
                    acc_r <= sum;
                    dout  <= sum;
                    if (sum_ovf) begin
                        acc_ovf <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_main_mul_acc_pipe.sv
// tb/tb_main_mul_acc_pipe.sv - self-checking bench for main_mul_acc_pipe
module tb_main_mul_acc_pipe;

    typedef struct {
        bit          v;
        bit          acc;
        bit          first;
        logic [255:0] a;
        logic [255:0] b;
    } ent_t;

    int W0 [3] = '{170, 16, 16};
    int W1 [3] = '{53, 16, 12};
    int DW [3] = '{170, 8, 20};
    int NS [3] = '{5, 5, 2};
    int S0 [3] = '{1, 1, 1};
    int S1 [3] = '{0, 1, 0};

    logic clk = 1'b0;
    logic reset;
    logic ce;
    logic         vld    [3];
    logic         accf   [3];
    logic         firstf [3];
    logic [255:0] a_in   [3];
    logic [255:0] b_in   [3];

    logic [169:0] dout0;
    logic [7:0]   dout1;
    logic [19:0]  dout2;
    logic         ovld0, ovld1, ovld2;
    logic         ovf0, ovf1, ovf2;
    logic [169:0] d0_0;
    logic [52:0]  d1_0;
    logic [15:0]  d0_1, d1_1, d0_2;
    logic [11:0]  d1_2;

    assign d0_0 = a_in[0][169:0];
    assign d1_0 = b_in[0][52:0];
    assign d0_1 = a_in[1][15:0];
    assign d1_1 = b_in[1][15:0];
    assign d0_2 = a_in[2][15:0];
    assign d1_2 = b_in[2][11:0];

    ent_t         pq [3][$];
    logic [255:0] exp_dout [3];
    logic [255:0] macc     [3];
    bit           exp_vld  [3];
    bit           exp_ovf  [3];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    main_mul_acc_pipe u0 (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(vld[0]), .in_acc(accf[0]), .in_first(firstf[0]),
        .din0(d0_0), .din1(d1_0), .dout(dout0), .out_vld(ovld0), .acc_ovf(ovf0)
    );

    main_mul_acc_pipe #(.din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(8), .NUM_STAGE(5),
                        .DIN0_SIGNED(1), .DIN1_SIGNED(1)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(vld[1]), .in_acc(accf[1]), .in_first(firstf[1]),
        .din0(d0_1), .din1(d1_1), .dout(dout1), .out_vld(ovld1), .acc_ovf(ovf1)
    );

    main_mul_acc_pipe #(.din0_WIDTH(16), .din1_WIDTH(12), .dout_WIDTH(20), .NUM_STAGE(2),
                        .DIN0_SIGNED(1), .DIN1_SIGNED(0)) u2 (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(vld[2]), .in_acc(accf[2]), .in_first(firstf[2]),
        .din0(d0_2), .din1(d1_2), .dout(dout2), .out_vld(ovld2), .acc_ovf(ovf2)
    );

    function automatic logic [255:0] msk(logic [255:0] x, int w);
        logic [255:0] m;
        m = (w >= 256) ? '1 : ((256'd1 << w) - 256'd1);
        return x & m;
    endfunction

    function automatic logic [255:0] sext(logic [255:0] x, int w, int s);
        logic [255:0] m;
        logic [255:0] y;
        m = msk('1, w);
        y = x & m;
        if (s != 0 && y[w-1]) y = y | ~m;
        return y;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [255:0] obs_dout(int k);
        case (k)
            0:       return 256'(dout0);
            1:       return 256'(dout1);
            default: return 256'(dout2);
        endcase
    endfunction

    function automatic logic [255:0] obs_vld(int k);
        case (k)
            0:       return 256'(ovld0);
            1:       return 256'(ovld1);
            default: return 256'(ovld2);
        endcase
    endfunction

    function automatic logic [255:0] obs_ovf(int k);
        case (k)
            0:       return 256'(ovf0);
            1:       return 256'(ovf1);
            default: return 256'(ovf2);
        endcase
    endfunction

    task automatic model_reset();
        ent_t z;
        z = '{v: 1'b0, acc: 1'b0, first: 1'b0, a: '0, b: '0};
        for (int k = 0; k < 3; k++) begin
            pq[k].delete();
            for (int j = 0; j < NS[k] - 1; j++) pq[k].push_back(z);
            exp_dout[k] = '0;
            macc[k]     = '0;
            exp_vld[k]  = 1'b0;
            exp_ovf[k]  = 1'b0;
        end
    endtask

    task automatic model_result(int k, ent_t e);
        logic [255:0] p;
        logic [255:0] s;
        bit           o;
        exp_vld[k] = e.v;
        if (!e.v) return;
        p = msk(sext(e.a, W0[k], S0[k]) * sext(e.b, W1[k], S1[k]), DW[k]);
        if (!e.acc) begin
            exp_dout[k] = p;
        end else if (e.first) begin
            macc[k]     = p;
            exp_dout[k] = p;
            exp_ovf[k]  = 1'b0;
        end else begin
            if (S0[k] != 0 || S1[k] != 0) begin
                s = sext(macc[k], DW[k], 1) + sext(p, DW[k], 1);
                o = (sext(msk(s, DW[k]), DW[k], 1) != s);
            end else begin
                s = macc[k] + p;
                o = ((s >> DW[k]) != 0);
            end
            macc[k]     = msk(s, DW[k]);
            exp_dout[k] = macc[k];
            if (o) exp_ovf[k] = 1'b1;
        end
    endtask

    task automatic model_edge();
        ent_t e;
        ent_t f;
        if (reset || !ce) return;
        for (int k = 0; k < 3; k++) begin
            e = '{v: vld[k], acc: accf[k], first: firstf[k], a: a_in[k], b: b_in[k]};
            pq[k].push_back(e);
            f = pq[k].pop_front();
            model_result(k, f);
        end
    endtask

    task automatic check_all(string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_u%0d_vld", tag, k), obs_vld(k), 256'(exp_vld[k]));
            chk($sformatf("%s_u%0d_dout", tag, k), obs_dout(k), exp_dout[k]);
            chk($sformatf("%s_u%0d_ovf", tag, k), obs_ovf(k), 256'(exp_ovf[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_all("model");
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            vld[k]    = 1'b0;
            accf[k]   = 1'b0;
            firstf[k] = 1'b0;
        end
    endtask

    task automatic set_op(int k, logic [255:0] a, logic [255:0] b, bit acc, bit first);
        vld[k]    = 1'b1;
        accf[k]   = acc;
        firstf[k] = first;
        a_in[k]   = a;
        b_in[k]   = b;
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
        end
        idle();
        model_reset();
        #2;
        check_all("reset");
        step();
        step();
        reset = 1'b0;

        // single signed multiply, latency 5
        set_op(0, 256'(-3), 256'd7, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 1) idle();
            if (i == 5) begin
                chk("mul_vld", 256'(ovld0), 256'd1);
                chk("mul_dout", 256'(dout0), msk(256'(-21), 170));
            end else begin
                chk("mul_vld_idle", 256'(ovld0), 256'd0);
            end
        end

        // back-to-back accumulate
        for (int i = 1; i <= 9; i++) begin
            case (i)
                1:       set_op(0, 256'd2, 256'd3, 1'b1, 1'b1);
                2:       set_op(0, 256'd4, 256'd5, 1'b1, 1'b0);
                3:       set_op(0, 256'd6, 256'd7, 1'b1, 1'b0);
                default: idle();
            endcase
            step();
            if (i == 5) chk("acc_d0", 256'(dout0), 256'd6);
            if (i == 6) chk("acc_d1", 256'(dout0), 256'd26);
            if (i == 7) begin
                chk("acc_d2", 256'(dout0), 256'd68);
                chk("acc_ovf", 256'(ovf0), 256'd0);
            end
        end

        // three-cycle stall with two operations in flight
        for (int i = 1; i <= 11; i++) begin
            case (i)
                1:       set_op(0, 256'd5, 256'd3, 1'b0, 1'b0);
                2:       set_op(0, 256'(-2), 256'd9, 1'b0, 1'b0);
                default: idle();
            endcase
            ce = !(i >= 4 && i <= 6);
            step();
            if (i >= 4 && i <= 7) chk("stall_vld", 256'(ovld0), 256'd0);
            if (i == 8) chk("stall_d0", 256'(dout0), 256'd15);
            if (i == 9) chk("stall_d1", 256'(dout0), msk(256'(-18), 170));
        end
        ce = 1'b1;

        // 8-bit signed accumulate overflow, then restart
        for (int i = 1; i <= 8; i++) begin
            case (i)
                1:       set_op(1, 256'd10, 256'd10, 1'b1, 1'b1);
                2:       set_op(1, 256'd10, 256'd10, 1'b1, 1'b0);
                3:       set_op(1, 256'd1, 256'd1, 1'b1, 1'b1);
                default: idle();
            endcase
            step();
            if (i == 5) chk("ovf_d0", 256'(dout1), 256'd100);
            if (i == 6) begin
                chk("ovf_d1", 256'(dout1), 256'hC8);
                chk("ovf_set", 256'(ovf1), 256'd1);
            end
            if (i == 7) begin
                chk("ovf_d2", 256'(dout1), 256'd1);
                chk("ovf_clr", 256'(ovf1), 256'd0);
            end
        end

        // two-stage pipe, full-range operands
        for (int i = 1; i <= 4; i++) begin
            if (i == 1) set_op(2, 256'h8000, 256'hFFF, 1'b0, 1'b0);
            else        idle();
            step();
            if (i == 1) chk("ns2_vld_early", 256'(ovld2), 256'd0);
            if (i == 2) begin
                chk("ns2_vld", 256'(ovld2), 256'd1);
                chk("ns2_dout", 256'(dout2), 256'h08000);
            end
        end

        // asynchronous reset with operations in flight
        for (int i = 1; i <= 3; i++) begin
            for (int k = 0; k < 3; k++) set_op(k, rnd256(), rnd256(), 1'b1, i == 1);
            step();
        end
        idle();
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("arst_vld", obs_vld(k), 256'd0);
            chk("arst_dout", obs_dout(k), 256'd0);
            chk("arst_ovf", obs_ovf(k), 256'd0);
        end
        model_reset();
        step();
        step();
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("arst_no_vld", 256'({ovld0, ovld1, ovld2}), 256'd0);
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            ce = ($urandom_range(0, 6) != 0);
            for (int k = 0; k < 3; k++) begin
                vld[k]    = ($urandom_range(0, 9) < 7);
                accf[k]   = ($urandom_range(0, 9) < 6);
                firstf[k] = ($urandom_range(0, 9) < 2);
                a_in[k]   = rnd256();
                b_in[k]   = rnd256();
            end
            step();
        end
        ce = 1'b1;
        idle();
        for (int i = 0; i < 6; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
